// File: rtl/sc_fifo_if.sv
// sc_fifo handshake bundle: write side, read side, status.
// SC_FIFO_ERR_FLAGS_EN adds the sticky ovf_o/udf_o error outputs.
interface sc_fifo_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
);
  logic              wrreq_i;
  logic [DWIDTH-1:0] data_i;
  logic              rdreq_i;
  logic [DWIDTH-1:0] q_o;
  logic              empty_o;
  logic              full_o;
  logic [AWIDTH-1:0] usedw_o;
`ifdef SC_FIFO_ERR_FLAGS_EN
  logic              ovf_o;
  logic              udf_o;
`endif

  modport master (
    output wrreq_i, data_i, rdreq_i,
`ifdef SC_FIFO_ERR_FLAGS_EN
    input  ovf_o, udf_o,
`endif
    input  q_o, empty_o, full_o, usedw_o
  );

  modport slave (
    input  wrreq_i, data_i, rdreq_i,
`ifdef SC_FIFO_ERR_FLAGS_EN
    output ovf_o, udf_o,
`endif
    output q_o, empty_o, full_o, usedw_o
  );
endinterface

// File: rtl/sc_fifo.sv
// Single-clock FIFO, cycle-exact scfifo replacement (normal/show-ahead).
// Optional macro SC_FIFO_ERR_FLAGS_EN: sticky ovf_o/udf_o plus SVA warnings.
module sc_fifo #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter     SHOWAHEAD = "OFF"
) (
  input  logic        clk_i,
  input  logic        srst_i,
  sc_fifo_if.slave    bus
);
  localparam int          DEPTH = 1 << AWIDTH;
  localparam [AWIDTH:0]   CFULL = {1'b1, {AWIDTH{1'b0}}};

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [AWIDTH:0]   cnt_q, cnt_d;
  logic              empty_q, full_q;
  logic [AWIDTH-1:0] usedw_q;
  logic              wr_en, rd_en;

  // Requests are qualified by the registered flags only.
  assign wr_en = bus.wrreq_i & ~full_q;
  assign rd_en = bus.rdreq_i & ~empty_q;
  assign cnt_d = cnt_q + (AWIDTH+1)'(wr_en)
                       - (AWIDTH+1)'(rd_en);

  assign bus.empty_o = empty_q;
  assign bus.full_o  = full_q;
  assign bus.usedw_o = usedw_q;

  // Storage array; no reset, a read never hits the write address.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.data_i;
  end

  // Pointers, count and registered status flags.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      usedw_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CFULL);
      usedw_q <= cnt_d[AWIDTH-1:0];
    end
  end

  if (SHOWAHEAD == "ON") begin : g_sa
    assign bus.q_o = mem_q[rd_ptr_q];
  end else begin : g_nrm
    logic [DWIDTH-1:0] q_q;
    // Registered read data, updated only on an accepted read.
    always_ff @(posedge clk_i) begin
      if (srst_i)     q_q <= '0;
      else if (rd_en) q_q <= mem_q[rd_ptr_q];
    end
    assign bus.q_o = q_q;
  end

`ifdef SC_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;
  // Sticky misuse flags, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wrreq_i & full_q)  ovf_q <= 1'b1;
      if (bus.rdreq_i & empty_q) udf_q <= 1'b1;
    end
  end
  assign bus.ovf_o = ovf_q;
  assign bus.udf_o = udf_q;

  a_no_ovf : assert property (@(posedge clk_i) disable iff (srst_i)
    bus.wrreq_i |-> !full_q)
    else $warning("sc_fifo: write while full");
  a_no_udf : assert property (@(posedge clk_i) disable iff (srst_i)
    bus.rdreq_i |-> !empty_q)
    else $warning("sc_fifo: read while empty");
`endif
endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo, both read modes driven in lockstep.
// Queue reference plus hand-computed boundary constants.
module tb_sc_fifo;
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  sc_fifo_if #(.DWIDTH(8), .AWIDTH(4)) ifn ();
  sc_fifo_if #(.DWIDTH(8), .AWIDTH(4)) ifs ();

  sc_fifo #(.DWIDTH(8), .AWIDTH(4), .SHOWAHEAD("OFF")) u_nrm (
    .clk_i(clk), .srst_i(srst), .bus(ifn.slave));
  sc_fifo #(.DWIDTH(8), .AWIDTH(4), .SHOWAHEAD("ON")) u_sa (
    .clk_i(clk), .srst_i(srst), .bus(ifs.slave));

  int checks = 0;
  int errors = 0;
  logic [7:0] fq [$];
  logic [7:0] qn_exp;
  int cnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    ifn.wrreq_i = w; ifn.data_i = d; ifn.rdreq_i = r;
    ifs.wrreq_i = w; ifs.data_i = d; ifs.rdreq_i = r;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".n.usedw"}, 32'(ifn.usedw_o), 32'(cnt % 16));
    chk({tag, ".n.empty"}, 32'(ifn.empty_o), 32'(cnt == 0));
    chk({tag, ".n.full"},  32'(ifn.full_o),  32'(cnt == 16));
    chk({tag, ".n.q"},     32'(ifn.q_o),     32'(qn_exp));
    chk({tag, ".s.usedw"}, 32'(ifs.usedw_o), 32'(cnt % 16));
    chk({tag, ".s.empty"}, 32'(ifs.empty_o), 32'(cnt == 0));
    chk({tag, ".s.full"},  32'(ifs.full_o),  32'(cnt == 16));
    if (cnt > 0)
      chk({tag, ".s.q"}, 32'(ifs.q_o), 32'(fq[0]));
  endtask

  task automatic step(input string tag, input logic w,
                      input logic [7:0] d, input logic r);
    bit wa, ra;
    @(negedge clk);
    drive(w, d, r);
    @(posedge clk);
    wa = w && (cnt < 16);
    ra = r && (cnt > 0);
    if (ra) qn_exp = fq.pop_front();
    if (wa) fq.push_back(d);
    cnt = fq.size();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst = 1'b1;
    drive(1'b1, 8'hA5, 1'b1);
    @(posedge clk);
    fq.delete();
    cnt = 0;
    qn_exp = 8'h00;
    @(negedge clk);
    srst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    srst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    cnt = 0;
    qn_exp = 8'h00;
    repeat (2) @(posedge clk);
    do_reset();
    #1;
    chk("rst.n.q", 32'(ifn.q_o), 32'h00);
    chk("rst.n.empty", 32'(ifn.empty_o), 32'h1);
    chk("rst.n.full", 32'(ifn.full_o), 32'h0);
    chk("rst.s.usedw", 32'(ifs.usedw_o), 32'h0);

    for (int i = 0; i < 16; i++) begin
      step("fill", 1'b1, 8'(8'h10 + i), 1'b0);
      if (i == 0) chk("fill1.empty", 32'(ifn.empty_o), 32'h0);
      if (i == 14) chk("fill15.usedw", 32'(ifn.usedw_o), 32'd15);
    end
    chk("fill16.full", 32'(ifn.full_o), 32'h1);
    chk("fill16.usedw", 32'(ifn.usedw_o), 32'h0);

    step("ovf", 1'b1, 8'hEE, 1'b0);
    chk("ovf.usedw", 32'(ifn.usedw_o), 32'h0);
    chk("ovf.full", 32'(ifs.full_o), 32'h1);

    for (int i = 0; i < 16; i++) begin
      step("drain", 1'b0, 8'h00, 1'b1);
      if (i == 0) chk("drain1.q", 32'(ifn.q_o), 32'h10);
    end
    chk("drain16.q", 32'(ifn.q_o), 32'h1F);
    chk("drain16.empty", 32'(ifn.empty_o), 32'h1);

    step("udf", 1'b0, 8'h00, 1'b1);
    step("udf", 1'b0, 8'h00, 1'b1);
    chk("udf.q_hold", 32'(ifn.q_o), 32'h1F);
    chk("udf.usedw", 32'(ifn.usedw_o), 32'h0);

    for (int i = 0; i < 16; i++)
      step("refill", 1'b1, 8'(8'h40 + i), 1'b0);
    step("wr_rd_full", 1'b1, 8'hEF, 1'b1);
    chk("wrrdfull.usedw", 32'(ifn.usedw_o), 32'd15);
    chk("wrrdfull.q", 32'(ifn.q_o), 32'h40);
    step("rd1", 1'b0, 8'h00, 1'b1);
    step("wr+rd", 1'b1, 8'h60, 1'b1);
    chk("fb.usedw14", 32'(ifn.usedw_o), 32'd14);
    step("w", 1'b1, 8'h61, 1'b0);
    step("w", 1'b1, 8'h62, 1'b0);
    chk("fb.full", 32'(ifn.full_o), 32'h1);
    while (cnt > 0) step("drain2", 1'b0, 8'h00, 1'b1);
    chk("drain2.q", 32'(ifn.q_o), 32'h62);

    step("wr_rd_empty", 1'b1, 8'h77, 1'b1);
    chk("wrrdempty.usedw", 32'(ifn.usedw_o), 32'd1);
    chk("wrrdempty.q_hold", 32'(ifn.q_o), 32'h62);
    step("eb.wr+rd", 1'b1, 8'h78, 1'b1);
    chk("eb.usedw", 32'(ifn.usedw_o), 32'd1);
    chk("eb.q", 32'(ifn.q_o), 32'h77);
    step("eb.rd", 1'b0, 8'h00, 1'b1);
    chk("eb.empty", 32'(ifn.empty_o), 32'h1);
    chk("eb.q78", 32'(ifn.q_o), 32'h78);

    for (int i = 0; i < 120; i++)
      step("rnd_fill", 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 3) == 0));
    for (int i = 0; i < 120; i++)
      step("rnd_drain", 1'($urandom_range(0, 3) == 0),
           8'($urandom), 1'($urandom_range(0, 1)));

    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 8'(8'hC0 + i), 1'b0);
    do_reset();
    #1;
    check_all("midrst");
    step("post_rst_w", 1'b1, 8'h5A, 1'b0);
    chk("postrst.s.q", 32'(ifs.q_o), 32'h5A);
    step("post_rst_r", 1'b0, 8'h00, 1'b1);
    chk("postrst.n.q", 32'(ifn.q_o), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
